// File: rtl/byte_scan_display.sv
// Byte-serial display scanner: shows a snapshotted word one byte per slot, LSB first, then separator slots.
// Optional BYTE_SCAN_MARKER_EN: blank slots drive 8'hA5 instead of 8'h00.
module byte_scan_display #(
   parameter int WORD_W      = 16,
   parameter int DWELL       = 8_000_000,
   parameter int BLANK_SLOTS = 1,
   localparam int NBYTES     = (WORD_W + 7) / 8,
   localparam int NSLOTS     = NBYTES + BLANK_SLOTS,
   localparam int SLOT_W     = (NSLOTS > 1) ? $clog2(NSLOTS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] value,
   input  logic              value_valid,
   output logic [7:0]        disp,
   output logic [SLOT_W-1:0] slot_idx,
   output logic              frame_start,
   output logic              overrun
);
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int PAD_W = NBYTES * 8;
`ifdef BYTE_SCAN_MARKER_EN
   localparam logic [7:0] BLANK_BYTE = 8'hA5;
`else
   localparam logic [7:0] BLANK_BYTE = 8'h00;
`endif

   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [SLOT_W-1:0] slot_reg, slot_next;
   logic [WORD_W-1:0] shown_reg, shown_next;
   logic [WORD_W-1:0] pending_reg, pending_next;
   logic              pend_vld_reg, pend_vld_next;
   logic [7:0]        disp_reg, disp_next;
   logic              frame_start_reg, frame_start_next;
   logic              overrun_reg, overrun_next;
   logic              dwell_end, wrap;
   logic [PAD_W-1:0]  shown_pad;
   logic [7:0]        byte_sel [NBYTES];

   // Bytes are taken from the next shown value so the first slot of a new frame is already coherent.
   always_comb begin
      shown_pad = '0;
      shown_pad[WORD_W-1:0] = shown_next;
   end

   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign byte_sel[gi] = shown_pad[gi*8 +: 8];
   end

   always_comb begin
      dwell_end        = (cnt_reg == CNT_W'(DWELL - 1));
      wrap             = dwell_end && (slot_reg == SLOT_W'(NSLOTS - 1));
      cnt_next         = dwell_end ? '0 : cnt_reg + 1'b1;
      slot_next        = slot_reg;
      shown_next       = shown_reg;
      pending_next     = pending_reg;
      pend_vld_next    = pend_vld_reg;
      frame_start_next = wrap;
      overrun_next     = value_valid && pend_vld_reg && !wrap;

      if (dwell_end)
         slot_next = wrap ? '0 : slot_reg + 1'b1;

      if (value_valid) begin
         pending_next  = value;
         pend_vld_next = 1'b1;
      end

      // A value arriving on the wrap cycle goes straight to the display and supersedes any pending one.
      if (wrap) begin
         if (value_valid)
            shown_next = value;
         else if (pend_vld_reg)
            shown_next = pending_reg;
         pend_vld_next = 1'b0;
      end

      disp_next = BLANK_BYTE;
      for (int i = 0; i < NBYTES; i++) begin
         if (slot_next == SLOT_W'(i))
            disp_next = byte_sel[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg         <= '0;
         slot_reg        <= '0;
         shown_reg       <= '0;
         pending_reg     <= '0;
         pend_vld_reg    <= 1'b0;
         disp_reg        <= 8'h00;
         frame_start_reg <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         cnt_reg         <= cnt_next;
         slot_reg        <= slot_next;
         shown_reg       <= shown_next;
         pending_reg     <= pending_next;
         pend_vld_reg    <= pend_vld_next;
         disp_reg        <= disp_next;
         frame_start_reg <= frame_start_next;
         overrun_reg     <= overrun_next;
      end
   end

   assign disp        = disp_reg;
   assign slot_idx    = slot_reg;
   assign frame_start = frame_start_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_byte_scan_display.sv
// Bench for byte_scan_display: frame-level timing model for a 16-bit/DWELL=4 instance plus literal checks,
// and a 20-bit/DWELL=1 instance checked with literal frame contents.
module tb_byte_scan_display;
   localparam int DWELL  = 4;
   localparam int NBYTES = 2;
   localparam int NSLOTS = 3;
`ifdef BYTE_SCAN_MARKER_EN
   localparam logic [7:0] BLANK = 8'hA5;
`else
   localparam logic [7:0] BLANK = 8'h00;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic        value_valid = 1'b0;
   logic [7:0]  disp;
   logic [1:0]  slot_idx;
   logic        frame_start, overrun;

   logic [19:0] value20 = '0;
   logic        valid20 = 1'b0;
   logic [7:0]  disp20;
   logic [1:0]  slot20;
   logic        fs20, over20;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   byte_scan_display #(.WORD_W(16), .DWELL(DWELL), .BLANK_SLOTS(1)) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
      .disp(disp), .slot_idx(slot_idx), .frame_start(frame_start), .overrun(overrun));

   byte_scan_display #(.WORD_W(20), .DWELL(1), .BLANK_SLOTS(1)) dut20 (
      .clk(clk), .rst_n(rst_n), .value(value20), .value_valid(valid20),
      .disp(disp20), .slot_idx(slot20), .frame_start(fs20), .overrun(over20));

   // Model: time since reset decides slot and frame boundaries; frame content is latched per frame.
   int          t = 0;
   logic [15:0] m_shown = '0, m_pend = '0;
   bit          m_pend_vld = 1'b0;
   logic [7:0]  exp_disp = '0;
   logic [1:0]  exp_slot = '0;
   logic        exp_fs = 1'b0, exp_over = 1'b0;

   always @(posedge clk) begin
      int slot;
      bit last_cycle_of_frame;
      if (!rst_n) begin
         t = 0; m_shown = '0; m_pend = '0; m_pend_vld = 1'b0; exp_over = 1'b0;
      end else begin
         last_cycle_of_frame = ((t + 1) % (DWELL * NSLOTS)) == 0;
         exp_over = value_valid && m_pend_vld && !last_cycle_of_frame;
         if (last_cycle_of_frame) begin
            if (value_valid) m_shown = value;
            else if (m_pend_vld) m_shown = m_pend;
            m_pend_vld = 1'b0;
         end else if (value_valid) begin
            m_pend = value;
            m_pend_vld = 1'b1;
         end
         t++;
      end
      slot     = (t / DWELL) % NSLOTS;
      exp_slot = 2'(slot);
      exp_fs   = (t > 0) && (t % (DWELL * NSLOTS) == 0);
      exp_disp = (slot < NBYTES) ? 8'((m_shown >> (8 * slot)) & 16'hFF) : BLANK;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (disp !== exp_disp || slot_idx !== exp_slot || frame_start !== exp_fs || overrun !== exp_over) begin
            errors++;
            $display("FAIL model t=%0d: got disp=%h slot=%0d fs=%b ov=%b, need disp=%h slot=%0d fs=%b ov=%b",
                     t, disp, slot_idx, frame_start, overrun, exp_disp, exp_slot, exp_fs, exp_over);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %h, need %h", name, cyc, got, want);
      end
   endtask

   task automatic tick(input logic v, input logic [15:0] d);
      value_valid = v;
      value = d;
      if (v) $display("txn cyc=%0d value=%h", cyc, d);
      @(negedge clk);
      cyc++;
      value_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_disp"}, 32'(disp), 32'h00);
      check({tag, "_slot"}, 32'(slot_idx), 32'h0);
      check({tag, "_fs"}, 32'(frame_start), 32'h0);
      check({tag, "_ov"}, 32'(overrun), 32'h0);
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      check_reset_state("rst");

      // Single value, repeated frame; 20-bit DWELL=1 instance runs alongside.
      for (int c = 0; c < 36; c++) begin
         case (c)
            5:  check("t1_pre", 32'(disp), 32'h00);
            11: check("t1_nofs", 32'(frame_start), 32'h0);
            12: begin check("t1_b0", 32'(disp), 32'h34); check("t1_fs", 32'(frame_start), 32'h1); end
            16: check("t1_b1", 32'(disp), 32'h12);
            20: check("t1_blank", 32'(disp), 32'(BLANK));
            24: begin check("t1_rep", 32'(disp), 32'h34); check("t1_fs2", 32'(frame_start), 32'h1); end
            4:  begin check("w20_b0", 32'(disp20), 32'hDE); check("w20_fs", 32'(fs20), 32'h1);
                      check("w20_s0", 32'(slot20), 32'h0); end
            6:  begin check("w20_b2", 32'(disp20), 32'h0A); check("w20_s2", 32'(slot20), 32'h2); end
            7:  begin check("w20_blank", 32'(disp20), 32'(BLANK)); check("w20_s3", 32'(slot20), 32'h3);
                      check("w20_nofs", 32'(fs20), 32'h0); end
            8:  begin check("w20_wrap", 32'(disp20), 32'hDE); check("w20_fs2", 32'(fs20), 32'h1); end
            default: ;
         endcase
         if (c == 5) check("w20_b1", 32'(disp20), 32'hBC);
         valid20 = (c == 1);
         value20 = 20'hABCDE;
         tick(c == 2, 16'h1234);
      end
      valid20 = 1'b0;

      // Overwrite of an unconsumed pending value.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         case (c)
            5:  check("t2_ov5", 32'(overrun), 32'h0);
            6:  check("t2_ov6", 32'(overrun), 32'h1);
            7:  check("t2_ov7", 32'(overrun), 32'h0);
            12: check("t2_b0", 32'(disp), 32'hBB);
            16: check("t2_b1", 32'(disp), 32'hBB);
            default: ;
         endcase
         tick(c == 3 || c == 5, (c == 3) ? 16'hAAAA : 16'hBBBB);
      end

      // Valid on the wrap cycle bypasses a pending value without overrun.
      do_reset();
      for (int c = 0; c < 26; c++) begin
         case (c)
            12: begin check("t3_b0", 32'(disp), 32'h78); check("t3_fs", 32'(frame_start), 32'h1);
                      check("t3_ov", 32'(overrun), 32'h0); end
            16: check("t3_b1", 32'(disp), 32'h56);
            24: check("t3_rep", 32'(disp), 32'h78);
            default: ;
         endcase
         tick(c == 4 || c == 11, (c == 4) ? 16'h9999 : 16'h5678);
      end

      // Mid-slot reset discards the pending value.
      do_reset();
      for (int c = 0; c < 6; c++) tick(c == 2, 16'h4321);
      check("t4_slot1", 32'(slot_idx), 32'h1);
      rst_n = 1'b0;
      tick(1'b0, 16'h0);
      rst_n = 1'b1;
      cyc = 0;
      check_reset_state("t4");
      for (int c = 0; c < 16; c++) begin
         if (c == 12) begin
            check("t4_b0", 32'(disp), 32'h00);
            check("t4_fs", 32'(frame_start), 32'h1);
         end
         tick(1'b0, 16'h0);
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
